// File: rtl/vga_pixel_pipeline.sv
// VGA pixel pipeline: framebuffer fetch, palette lookup and sync alignment.
// Three-stage pipeline driven straight from the timing generator counters.
module vga_pixel_pipeline #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int H_START = 144,
    parameter int V_START = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic        fb_sel,
    output logic [17:0] fb_addr,
    input  logic [7:0]  fb_data,
    input  logic        pal_we,
    input  logic [7:0]  pal_waddr,
    input  logic [11:0] pal_wdata,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        Hsync_out,
    output logic        Vsync_out,
    output logic        fb_page,
    output logic        frame_start
);

    localparam logic [9:0] H_FIRST = 10'(H_START);
    localparam logic [9:0] V_FIRST = 10'(V_START);
    localparam logic [9:0] H_LAST  = 10'(H_START + 2 * FB_W - 1);
    localparam logic [9:0] V_LAST  = 10'(V_START + 2 * FB_H - 1);

    logic [9:0]  hcnt_q, hcnt_d;
    logic        pix_stb;
    logic [9:0]  x, y;
    logic [16:0] x17, y17, lin;
    logic        vis_now;

    logic [17:0] addr_q, addr_d;
    logic        vis1_q, vis1_d;
    logic        vis2_q, vis2_d;
    logic [7:0]  idx_q, idx_d;
    logic [11:0] rgb_q, rgb_d;
    logic [2:0]  hs_q, hs_d;
    logic [2:0]  vs_q, vs_d;
    logic        page_q, page_d;
    logic        fs_q, fs_d;

    logic [11:0] pal_q [256];

    // Palette storage: plain write port, contents survive reset.
    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_q[pal_waddr] <= pal_wdata;
        end
    end

    // Next-state for the pixel pipeline, sync delay line and page latch.
    always_comb begin
        hcnt_d  = hCount;
        pix_stb = (hCount != hcnt_q);

        x   = hCount - H_FIRST;
        y   = vCount - V_FIRST;
        x17 = {7'd0, x} >> 1;
        y17 = {7'd0, y} >> 1;
        lin = (y17 << 8) + (y17 << 6) + x17;

        vis_now = (hCount >= H_FIRST) && (hCount <= H_LAST) &&
                  (vCount >= V_FIRST) && (vCount <= V_LAST);

        vis1_d = vis_now;
        addr_d = vis_now ? {page_q, lin} : {page_q, 17'd0};

        idx_d  = fb_data;
        vis2_d = vis1_q;

        rgb_d  = vis2_q ? pal_q[idx_q] : 12'h000;

        hs_d = {hs_q[1:0], Hsync};
        vs_d = {vs_q[1:0], Vsync};

        page_d = page_q;
        fs_d   = 1'b0;
        if (pix_stb && (hCount == 10'd0) && (vCount == 10'd0)) begin
            page_d = fb_sel;
            fs_d   = 1'b1;
        end
    end

    // Pipeline registers with asynchronous reset to blank/idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= 10'd0;
            addr_q <= 18'd0;
            vis1_q <= 1'b0;
            vis2_q <= 1'b0;
            idx_q  <= 8'd0;
            rgb_q  <= 12'h000;
            hs_q   <= 3'b111;
            vs_q   <= 3'b111;
            page_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            addr_q <= addr_d;
            vis1_q <= vis1_d;
            vis2_q <= vis2_d;
            idx_q  <= idx_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            page_q <= page_d;
            fs_q   <= fs_d;
        end
    end

    assign fb_addr     = addr_q;
    assign vgaR        = rgb_q[11:8];
    assign vgaG        = rgb_q[7:4];
    assign vgaB        = rgb_q[3:0];
    assign Hsync_out   = hs_q[2];
    assign Vsync_out   = vs_q[2];
    assign fb_page     = page_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Testbench for vga_pixel_pipeline: randomized scan against a
// behavioural model, plus directed literal checks.
module tb_vga_pixel_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hCount = 10'd0;
    logic [9:0]  vCount = 10'd10;
    logic        Hsync = 1'b1;
    logic        Vsync = 1'b1;
    logic        fb_sel = 1'b0;
    logic [17:0] fb_addr;
    logic [7:0]  fb_data = 8'd0;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_waddr = 8'd0;
    logic [11:0] pal_wdata = 12'd0;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        Hsync_out, Vsync_out, fb_page, frame_start;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    vga_pixel_pipeline dut (
        .clk(clk), .reset(reset),
        .hCount(hCount), .vCount(vCount),
        .Hsync(Hsync), .Vsync(Vsync),
        .fb_sel(fb_sel), .fb_addr(fb_addr), .fb_data(fb_data),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
        .Hsync_out(Hsync_out), .Vsync_out(Vsync_out),
        .fb_page(fb_page), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       vis;
        bit [7:0] data;
        bit       hs;
        bit       vs;
    } samp_t;

    samp_t       hist[$];
    bit [11:0]   pal_m [256];
    bit [17:0]   exp_addr;
    bit [11:0]   exp_rgb;
    bit          exp_hs, exp_vs, exp_page, exp_fs;
    bit [9:0]    prev_h;

    function automatic bit visible(int h, int v);
        return (h >= 144) && (h < 144 + 640) && (v >= 35) && (v < 35 + 480);
    endfunction

    function automatic samp_t rst_samp();
        samp_t s;
        s.vis = 0; s.data = 0; s.hs = 1; s.vs = 1;
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) pal_m[i] = 12'h000;
    end

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_front(rst_samp());
            exp_addr = 0; exp_rgb = 0; exp_hs = 1; exp_vs = 1;
            exp_page = 0; exp_fs = 0; prev_h = 0;
        end else begin
            samp_t s;
            int h, v, lin;
            h = int'(hCount);
            v = int'(vCount);
            s.vis = visible(h, v);
            s.data = fb_data;
            s.hs = Hsync;
            s.vs = Vsync;
            hist.push_front(s);
            while (hist.size() > 3) void'(hist.pop_back());
            // Colour uses visibility from two edges ago and the index
            // captured one edge ago, read before this edge's write.
            exp_rgb = hist[2].vis ? pal_m[hist[1].data] : 12'h000;
            exp_hs = hist[2].hs;
            exp_vs = hist[2].vs;
            lin = ((v - 35) / 2) * 320 + (h - 144) / 2;
            exp_addr = s.vis ? {exp_page, 17'(lin)} : {exp_page, 17'd0};
            exp_fs = (hCount != prev_h) && (h == 0) && (v == 0);
            if (exp_fs) exp_page = fb_sel;
            prev_h = hCount;
            if (pal_we) pal_m[pal_waddr] = pal_wdata;
        end
    end

    task automatic check(input string name, input logic [17:0] act,
                         input logic [17:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && chk_on) begin
            check("m_addr", fb_addr, exp_addr);
            check("m_rgb", 18'({vgaR, vgaG, vgaB}), 18'(exp_rgb));
            check("m_hs", 18'(Hsync_out), 18'(exp_hs));
            check("m_vs", 18'(Vsync_out), 18'(exp_vs));
            check("m_page", 18'(fb_page), 18'(exp_page));
            check("m_fs", 18'(frame_start), 18'(exp_fs));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input int h, input int v);
        hCount = 10'(h);
        vCount = 10'(v);
        Hsync = (h >= 96);
        Vsync = (v >= 2);
    endtask

    function automatic logic [17:0] rgb();
        return 18'({vgaR, vgaG, vgaB});
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, fb_addr, 18'd0);
        check({tag, "_rgb"}, rgb(), 18'd0);
        check({tag, "_hs"}, 18'(Hsync_out), 18'd1);
        check({tag, "_vs"}, 18'(Vsync_out), 18'd1);
        check({tag, "_page"}, 18'(fb_page), 18'd0);
        check({tag, "_fs"}, 18'(frame_start), 18'd0);
    endtask

    task automatic rand_pix(input int h, input int v);
        set_in(h, v);
        repeat (4) begin
            fb_data = 8'($urandom);
            pal_we = ($urandom_range(7) == 0);
            pal_waddr = 8'($urandom);
            pal_wdata = 12'($urandom);
            step();
        end
        pal_we = 1'b0;
    endtask

    initial begin
        int h, v;
        repeat (3) step();
        check_reset_vals("rst");
        reset = 1'b0;
        chk_on = 1'b1;

        // Load the palette while blanked.
        set_in(0, 10);
        for (int i = 0; i < 256; i++) begin
            pal_we = 1'b1;
            pal_waddr = 8'(i);
            pal_wdata = (i == 8'h5A) ? 12'hF3C :
                        (i == 8'h10) ? 12'h111 : 12'($urandom);
            step();
        end
        pal_we = 1'b0;
        repeat (4) step();

        // Address map.
        set_in(145, 37);
        step();
        check("addr_320", fb_addr, 18'd320);
        set_in(783, 514);
        step();
        check("addr_last", fb_addr, 18'd76799);

        // Blanking and colour path.
        fb_data = 8'h5A;
        set_in(100, 100);
        repeat (3) step();
        check("blank_h", rgb(), 18'd0);
        set_in(200, 100);
        repeat (2) step();
        check("col_early", rgb(), 18'd0);
        step();
        check("col_f3c", rgb(), 18'h0F3C);
        set_in(200, 515);
        repeat (3) step();
        check("blank_v515", rgb(), 18'd0);

        // Hsync delay.
        set_in(200, 10);
        repeat (4) step();
        set_in(0, 10);
        repeat (2) step();
        check("hs_early", 18'(Hsync_out), 18'd1);
        step();
        check("hs_low", 18'(Hsync_out), 18'd0);
        step();

        // Palette collision.
        fb_data = 8'h10;
        set_in(204, 100);
        repeat (2) step();
        pal_we = 1'b1; pal_waddr = 8'h10; pal_wdata = 12'h0F0;
        step();
        pal_we = 1'b0;
        check("coll_old", rgb(), 18'h0111);
        set_in(208, 100);
        repeat (3) step();
        check("coll_new", rgb(), 18'h00F0);

        // Page swap.
        set_in(300, 200);
        fb_sel = 1'b1;
        repeat (4) step();
        check("page_hold", 18'(fb_page), 18'd0);
        set_in(799, 524);
        repeat (4) step();
        check("page_hold2", 18'(fb_page), 18'd0);
        set_in(0, 0);
        step();
        check("fs_pulse", 18'(frame_start), 18'd1);
        check("page_new", 18'(fb_page), 18'd1);
        step();
        check("fs_single", 18'(frame_start), 18'd0);
        set_in(300, 100);
        step();
        check("addr_page1", fb_addr, {1'b1, 17'd10318});
        repeat (3) step();

        // Randomized scan with jumps, page requests and a mid-line reset.
        h = 140; v = 34;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(3))
                    0: begin h = 799; v = 524; end
                    1: begin h = 780; v = 514; end
                    2: begin h = 140; v = 515; end
                    default: begin
                        h = $urandom_range(799);
                        v = $urandom_range(524);
                    end
                endcase
            end else begin
                h++;
                if (h == 800) begin
                    h = 0;
                    v = (v == 524) ? 0 : v + 1;
                end
            end
            if ($urandom_range(49) == 0) fb_sel = ~fb_sel;
            if (n == 1500) begin
                set_in(300, 120);
                #2 reset = 1'b1;
                #1 check_reset_vals("midrst");
                step();
                step();
                reset = 1'b0;
                h = 300; v = 120;
            end
            rand_pix(h, v);
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
